uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Buffering and handshake stage directly upstream of uart_transmitter.
- Accepts bytes from a host-side push interface into a FIFO.
- Drains the FIFO one byte at a time by driving the transmitter's Tx_DATA/Tx_WR inputs and observing Tx_BUSY.
- Shields the host from the transmitter's baud-rate timing; detects a transmitter that never acknowledges a write request.

Parameters:
- DEPTH, 16, number of byte entries in the FIFO (power of two).
- ADDR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 4096, clk cycles Tx_WR is held high waiting for Tx_BUSY to rise before the byte is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  push strobe, one byte per cycle.
- tx_go  in  1  drain enable; when 0, no new byte is started.
- clr_err  in  1  clears the sticky error flags.
- Tx_BUSY  in  1  from uart_transmitter.
- Tx_DATA  out  8  to uart_transmitter; registered.
- Tx_WR  out  1  to uart_transmitter; registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a push was attempted while full.
- timeout_err  out  1  sticky; ACK_TIMEOUT expired.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: Tx_WR=0, Tx_DATA=8'h00, count=0, empty=1, full=0, overflow=0, timeout_err=0.
  - Internal: state=IDLE; read and write pointers = 0; timeout counter = 0.
  - Reset asserted mid-frame drops Tx_WR immediately and discards all FIFO contents.
- FIFO:
  - Circular buffer; pointers wrap DEPTH-1 -> 0.
  - A push is accepted iff wr_en=1 and full=0, judged on the registered full of that cycle. It is not accepted even if a pop occurs in the same cycle.
  - wr_en=1 while full: byte discarded, overflow<=1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - count, full and empty are registered and update on the edge after the push/pop.
- State machine:
  - IDLE:
    - Tx_WR=0.
    - If tx_go=1, empty=0 and Tx_BUSY=0 -> LOAD.
  - LOAD (1 cycle):
    - Tx_DATA <= FIFO[rd_ptr].
    - Timeout counter <= 0.
    - -> REQ.
  - REQ:
    - Tx_WR=1; counter increments each cycle.
    - Tx_BUSY=1 -> pop (rd_ptr++, count--), Tx_WR<=0, -> WAIT_DONE.
    - Else if counter == ACK_TIMEOUT-1 -> pop (byte abandoned), timeout_err<=1, Tx_WR<=0, -> IDLE.
  - WAIT_DONE:
    - Tx_WR=0.
    - Tx_BUSY=0 -> IDLE.
    - No timeout in this state.
- Latency and data stability:
  - Minimum 2 clk cycles from a byte becoming head-of-queue in IDLE to Tx_WR=1.
  - Tx_DATA holds stable from LOAD until the next LOAD.
- tx_go:
  - Deasserting tx_go only prevents leaving IDLE.
  - A byte already in LOAD, REQ or WAIT_DONE completes normally.
- Sticky flags:
  - clr_err=1 clears overflow and timeout_err on the next edge.
  - A new error event in the same cycle wins: the flag stays 1.
- Ordering: bytes are transmitted strictly in push order; no byte is sent twice.

Test Plan:
1. Push 8'hEB with tx_go=1, connected to uart_transmitter at baud_select=3'b010 -> Tx_DATA=8'hEB; Tx_WR high until Tx_BUSY rises; loopback uart_reciever shows Rx_DATA=8'hEB and Rx_VALID=1; count returns to 0.
2. Push 8'hEB, 8'hAB, 8'h55 back-to-back in consecutive cycles -> count=3; the three frames are transmitted in that order; each Tx_WR rise occurs only after the previous frame's Tx_BUSY fall.
3. tx_go=0, push 17 bytes into DEPTH=16 -> full=1 after the 16th; the 17th is discarded; overflow=1; clr_err pulse -> overflow=0; tx_go=1 drains exactly the 16 stored bytes.
4. Tx_BUSY tied to 0, push 8'h3C -> Tx_WR high for exactly 4096 cycles, then 0; timeout_err=1; count=0; FSM in IDLE.
5. Assert reset=0 while in WAIT_DONE with 5 bytes queued -> Tx_WR=0 and count=0 within the same cycle (asynchronous); after release, no transmission until a new push.
6. With full=1, apply wr_en=1 in the same cycle as the REQ->WAIT_DONE pop -> push rejected; overflow=1; count=15 on the next edge.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and write handshake that feeds uart_transmitter.
// Isolates the host from baud timing and abandons bytes the transmitter never acknowledges.
module uart_tx_feeder #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              tx_go,
  input  logic              clr_err,
  input  logic              Tx_BUSY,
  output logic [7:0]        Tx_DATA,
  output logic              Tx_WR,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W:0]   count_next;
  logic              push, pop, load, tmo_hit, tmo_fire, wr_next;

  assign push    = wr_en && !full;
  assign tmo_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (tx_go && !empty && !Tx_BUSY) state_next = LOAD;
      LOAD:      state_next = REQ;
      REQ: begin
        if (Tx_BUSY)      state_next = WAIT_DONE;
        else if (tmo_hit) state_next = IDLE;
      end
      WAIT_DONE: if (!Tx_BUSY) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == LOAD);
    pop      = (state == REQ) && (Tx_BUSY || tmo_hit);
    tmo_fire = (state == REQ) && !Tx_BUSY && tmo_hit;
    wr_next  = (state_next == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tx_WR   <= 1'b0;
      Tx_DATA <= '0;
      tmo_cnt <= '0;
    end else begin
      Tx_WR <= wr_next;
      if (load) begin
        Tx_DATA <= mem[rd_ptr];
        tmo_cnt <= '0;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (ADDR_W+1)'(1);
    else if (!push && pop) count_next = count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
      full  <= (count_next == (ADDR_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // A fresh error event in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (tmo_fire)      timeout_err <= 1'b1;
      else if (clr_err)  timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed plus randomized bench for uart_tx_feeder with a behavioural transmitter responder.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en, tx_go, clr_err;
  logic       Tx_BUSY = 1'b0;
  logic [7:0] Tx_DATA;
  logic       Tx_WR, full, empty, overflow, timeout_err;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic       resp_en = 1'b1;
  int         busy_min = 2;
  logic       pending = 1'b0;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .tx_go(tx_go),
    .clr_err(clr_err), .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter stand-in: acknowledges Tx_WR after 1..3 cycles, stays busy for a random frame time.
  initial begin
    int ack_dly = 0;
    int busy_cnt = 0;
    logic prev_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        Tx_BUSY = 1'b0; pending = 1'b0; busy_cnt = 0; ack_dly = 0; prev_wr = 1'b0;
      end else begin
        if (Tx_WR && !prev_wr) chk("wr_rise_while_busy", Tx_BUSY, 0);
        prev_wr = Tx_WR;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) Tx_BUSY = 1'b0;
        end else if (pending) begin
          ack_dly--;
          if (ack_dly == 0) begin
            chk("wr_held_until_ack", Tx_WR, 1);
            sent_q.push_back(Tx_DATA);
            Tx_BUSY = 1'b1;
            busy_cnt = $urandom_range(busy_min + 6, busy_min);
            pending = 1'b0;
          end
        end else if (resp_en && Tx_WR && !Tx_BUSY) begin
          pending = 1'b1;
          ack_dly = $urandom_range(3, 1);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    logic done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (empty && !Tx_WR && !Tx_BUSY && !pending) done = 1'b1;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic check_sent(input string tag);
    chk({tag, "_len"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, sent_q[i], exp_q[i]);
    sent_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         mcount;
    int         n;
    logic       hit;
    logic       any_wr;

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; tx_go = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_wr", Tx_WR, 0);
    chk("rst_tx_data", Tx_DATA, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single byte
    tx_go = 1'b1;
    exp_q.push_back(8'hEB);
    push_byte(8'hEB);
    wait_idle(200);
    chk("t1_tx_data", Tx_DATA, 8'hEB);
    chk("t1_count", count, 0);
    check_sent("t1");

    // Three back-to-back pushes, ordered drain
    tx_go = 1'b0;
    foreach (exp_q[i]) ;
    exp_q = '{8'hEB, 8'hAB, 8'h55};
    for (int i = 0; i < 3; i++) begin
      wr_data = exp_q[i]; wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("t2_count", count, 3);
    tx_go = 1'b1;
    wait_idle(400);
    check_sent("t2");

    // Overfill with drain disabled
    tx_go = 1'b0;
    mcount = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      wr_data = b; wr_en = 1'b1;
      if (mcount < DEPTH) begin
        exp_q.push_back(b);
        mcount++;
      end
      @(negedge clk);
      if (i == 14) chk("t3_not_full_15", full, 0);
      if (i == 15) chk("t3_full_16", full, 1);
    end
    wr_en = 1'b0;
    chk("t3_count", count, DEPTH);
    chk("t3_overflow", overflow, 1);
    wr_en = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr_err = 1'b0;
    chk("t3_ovf_wins_clr", overflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);
    chk("t3_count_kept", count, DEPTH);
    tx_go = 1'b1;
    wait_idle(2000);
    check_sent("t3");

    // Randomized bursts with drain running
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b);
        repeat ($urandom_range(4, 0)) @(negedge clk);
      end
      wait_idle(2000);
      chk("rnd_overflow", overflow, 0);
      check_sent("rnd");
    end

    // Push against full in the same cycle as a pop
    tx_go = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b);
    end
    chk("t6_full", full, 1);
    tx_go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (Tx_WR && Tx_BUSY) hit = 1'b1;
    end
    chk("t6_collide_seen", hit, 1);
    wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6_count", count, DEPTH - 1);
    chk("t6_overflow", overflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    wait_idle(2000);
    check_sent("t6");

    // Unacknowledged write request
    resp_en = 1'b0;
    tx_go = 1'b1;
    push_byte(8'h3C);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (Tx_WR) hit = 1'b1;
      else @(negedge clk);
    end
    chk("t4_wr_rose", hit, 1);
    chk("t4_tx_data", Tx_DATA, 8'h3C);
    n = 0;
    while (Tx_WR && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("t4_wr_high_cycles", n, 4096);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_count", count, 0);
    chk("t4_empty", empty, 1);
    repeat (5) @(negedge clk);
    chk("t4_no_retry", Tx_WR, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_timeout_cleared", timeout_err, 0);
    check_sent("t4");
    resp_en = 1'b1;

    // Asynchronous reset while waiting for frame completion
    busy_min = 30;
    tx_go = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    tx_go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (Tx_BUSY && !Tx_WR) hit = 1'b1;
    end
    chk("t5_wait_done_seen", hit, 1);
    chk("t5_count_before", count, 5);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_tx_wr", Tx_WR, 0);
    chk("t5_async_count", count, 0);
    chk("t5_async_empty", empty, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    busy_min = 2;
    sent_q.delete();
    exp_q.delete();
    any_wr = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (Tx_WR) any_wr = 1'b1;
    end
    chk("t5_no_tx_after_reset", any_wr, 0);
    exp_q.push_back(8'h5A);
    push_byte(8'h5A);
    wait_idle(200);
    check_sent("t5_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
